interrupt_controller: RTL

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

---
 rtl/intctl_pkg.sv | 19 +
 rtl/intctl_prio_enc.sv | 26 ++
 rtl/interrupt_controller.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/intctl_pkg.sv
// Shared definitions for the interrupt controller.
// Contents: default sizing constants, acknowledge-timeout length and the FSM state enum.
package intctl_pkg;

  localparam int unsigned DEF_NUM_IRQ    = 8;
  localparam int unsigned DEF_VEC_W      = 3;
  localparam int unsigned TIMEOUT_CYCLES = 255;
  localparam int unsigned TO_CNT_W       = 8;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StNreq,
    StSend,
    StClr,
    StWaitlo
  } intctl_state_e;

endpackage

// File: rtl/intctl_prio_enc.sv
// Combinational priority encoder: reports the lowest-numbered set request bit.
// Ports:
//   i_req   - request vector
//   o_idx   - index of the lowest set bit (0 when none)
//   o_valid - at least one request bit is set
module intctl_prio_enc #(
  parameter int unsigned NUM_IRQ = 8,
  parameter int unsigned VEC_W   = 3
) (
  input  logic [NUM_IRQ-1:0] i_req,
  output logic [VEC_W-1:0]   o_idx,
  output logic               o_valid
);

  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    for (int i = 0; i < int'(NUM_IRQ); i++) begin
      if (i_req[i] && !o_valid) begin
        o_idx   = VEC_W'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller with a maskable request bank, one edge-triggered NMI and a serial
// vector handshake (INT/INA, then the vector shifted out MSB first on INTD).
// Optional feature: define INTCTL_ACK_TIMEOUT_EN to abandon an unacknowledged INT/NMI after
// TIMEOUT_CYCLES cycles and expose the sticky ack_timeout flag.
// Ports:
//   clk, reset        - clock, asynchronous active-high reset
//   irq               - level requests (synchronous to clk)
//   nmi_req           - non-maskable request, rising-edge sensitive
//   mask_we/mask_wdata- mask register write (1 = line enabled)
//   INA               - processor acknowledge
//   INT, NMI          - registered interrupt requests to the processor
//   INTD              - serial vector data, 0 outside the send phase
//   pending           - pending register
//   busy              - FSM not idle
//   ack_timeout       - sticky timeout flag (only with INTCTL_ACK_TIMEOUT_EN)
module interrupt_controller
  import intctl_pkg::*;
#(
  parameter int unsigned NUM_IRQ = DEF_NUM_IRQ,
  parameter int unsigned VEC_W   = DEF_VEC_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               nmi_req,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               INA,
  output logic               INT,
  output logic               NMI,
  output logic               INTD,
  output logic [NUM_IRQ-1:0] pending,
`ifdef INTCTL_ACK_TIMEOUT_EN
  output logic               ack_timeout,
`endif
  output logic               busy
);

  intctl_state_e      r_state, w_state_d;
  logic [NUM_IRQ-1:0] r_mask;
  logic [NUM_IRQ-1:0] r_pending, w_pending_d;
  logic [NUM_IRQ-1:0] w_clr_mask;
  logic               r_nmi_prev;
  logic               r_nmi_pend, w_nmi_pend_d;
  logic               w_nmi_edge, w_nmi_clr;
  logic [VEC_W-1:0]   r_vec, w_vec_d;
  logic [VEC_W-1:0]   r_bit, w_bit_d;
  logic [VEC_W-1:0]   w_enc_idx;
  logic               w_enc_valid;
  logic               r_int, r_nmi;
  logic               w_waiting;
  logic               w_timeout;

  intctl_prio_enc #(
    .NUM_IRQ (NUM_IRQ),
    .VEC_W   (VEC_W)
  ) u_prio_enc (
    .i_req   (r_pending & r_mask),
    .o_idx   (w_enc_idx),
    .o_valid (w_enc_valid)
  );

  assign w_waiting = (r_state == StReq) || (r_state == StNreq);

`ifdef INTCTL_ACK_TIMEOUT_EN
  logic [TO_CNT_W-1:0] r_to_cnt, w_to_cnt_d;
  logic                r_ack_to, w_ack_to_d;

  // The count holds the number of cycles already spent waiting, so the request is dropped at
  // the end of the TIMEOUT_CYCLES-th waiting cycle.
  assign w_timeout = w_waiting && !INA && (r_to_cnt == TO_CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_to_cnt_d = '0;
    if (w_waiting && (w_state_d == r_state)) begin
      w_to_cnt_d = r_to_cnt + 1'b1;
    end
    w_ack_to_d = r_ack_to;
    if (mask_we) begin
      w_ack_to_d = 1'b0;
    end
    if (w_timeout) begin
      w_ack_to_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_to_cnt <= '0;
      r_ack_to <= 1'b0;
    end else begin
      r_to_cnt <= w_to_cnt_d;
      r_ack_to <= w_ack_to_d;
    end
  end

  assign ack_timeout = r_ack_to;
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_d  = r_state;
    w_vec_d    = r_vec;
    w_bit_d    = r_bit;
    w_nmi_clr  = 1'b0;
    w_clr_mask = '0;
    unique case (r_state)
      StIdle: begin
        // NMI always wins over maskable requests on IDLE exit.
        if (r_nmi_pend) begin
          w_state_d = StNreq;
        end else if (w_enc_valid) begin
          w_state_d = StReq;
          w_vec_d   = w_enc_idx;
        end
      end
      StNreq: begin
        if (INA) begin
          w_nmi_clr = 1'b1;
          w_state_d = StWaitlo;
        end else if (w_timeout) begin
          w_state_d = StIdle;
        end
      end
      StReq: begin
        if (INA) begin
          w_state_d = StSend;
          w_bit_d   = VEC_W'(VEC_W - 1);
        end else if (w_timeout) begin
          w_state_d = StIdle;
        end
      end
      StSend: begin
        if (r_bit == '0) begin
          w_state_d = StClr;
        end else begin
          w_bit_d = r_bit - 1'b1;
        end
      end
      StClr: begin
        w_clr_mask = NUM_IRQ'(1) << r_vec;
        w_state_d  = StWaitlo;
      end
      StWaitlo: begin
        if (!INA) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // New requests are OR-ed in after the clear so a same-cycle set wins.
  assign w_pending_d  = (r_pending & ~w_clr_mask) | (irq & r_mask);
  assign w_nmi_edge   = nmi_req & ~r_nmi_prev;
  assign w_nmi_pend_d = (r_nmi_pend & ~w_nmi_clr) | w_nmi_edge;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= StIdle;
      r_mask     <= '0;
      r_pending  <= '0;
      r_nmi_prev <= 1'b0;
      r_nmi_pend <= 1'b0;
      r_vec      <= '0;
      r_bit      <= '0;
      r_int      <= 1'b0;
      r_nmi      <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      if (mask_we) begin
        r_mask <= mask_wdata;
      end
      r_pending  <= w_pending_d;
      r_nmi_prev <= nmi_req;
      r_nmi_pend <= w_nmi_pend_d;
      r_vec      <= w_vec_d;
      r_bit      <= w_bit_d;
      r_int      <= (w_state_d == StReq);
      r_nmi      <= (w_state_d == StNreq);
    end
  end

  assign INT     = r_int;
  assign NMI     = r_nmi;
  assign INTD    = (r_state == StSend) ? r_vec[r_bit] : 1'b0;
  assign pending = r_pending;
  assign busy    = (r_state != StIdle);

endmodule
